ppu_line_fetcher: RTL
=====================

Name: ppu_line_fetcher

Overview:
- Parametrised background scanline fetch engine for the PPU.
- On each `line_start` it reads tile IDs from tile-buffer RAM and tile-row graphics from tile-graphics RAM into the back half of a double-buffered line store.
- A registered pixel port feeds the pixel mixer from the front half, with horizontal scroll and wrap.
- Generalises the fixed 40-tile, 1-cycle hsync loader: tiles per line, tile height and RAM read latency are parameters; line double-buffering and scroll are new.

Parameters:
- TILES_PER_LINE, 40, tiles per line; multiple of 4.
- TILE_H, 16, tile rows; power of 2.
- RD_LAT, 1, RAM read latency in cycles, >= 1; applies to both RAMs.
- TB_AW, 9, tile-buffer address width.
- TG_AW, 11, tile-graphics address width.
- Y_W, 10, line_y width.
- X_W, 11, px_x and scroll_x width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- line_start  in  1  pulse: fetch line `line_y` into back buffer
- line_y  in  Y_W  background line to fetch, sampled with line_start
- line_swap  in  1  pulse: exchange front and back buffers
- busy  out  1  fetch in progress
- done  out  1  one-cycle pulse when fetch completes
- tb_rd  out  1  tile-buffer read strobe
- tb_addr  out  TB_AW  tile-buffer word address
- tb_data  in  32  4 tile entries; entry k = bits [8k+7:8k]; bit7 = palette, [6:0] = tile id
- tg_rd  out  1  tile-graphics read strobe
- tg_addr  out  TG_AW  tile-graphics word address
- tg_data  in  32  one tile row; pixel p = bits [2p+1:2p], p = 0..15
- px_x  in  X_W  screen x of requested pixel
- scroll_x  in  X_W  horizontal scroll
- px_index  out  2  colour index, registered
- px_palette  out  1  palette select, registered

Behaviour:
- GROUPS = TILES_PER_LINE/4; LINE_PX = TILES_PER_LINE*16.
- Reset values:
  - busy=0, done=0, tb_rd=0, tg_rd=0, tb_addr=0, tg_addr=0, px_index=0, px_palette=0.
  - front select=0, swap_pending=0, FSM=IDLE.
  - Line store contents undefined after reset.
- FSM states: IDLE, GROUP, DONE.
- IDLE:
  - line_start=1 latches line_y, sets g=0, goes to GROUP, busy=1 on the next cycle.
  - line_start while busy is ignored.
- GROUP, per group g, with c = cycle offset 0 .. 2*RD_LAT+3:
  - c=0: tb_rd=1, tb_addr = (line_y/TILE_H)*GROUPS + g.
  - c=RD_LAT: capture 4 entries from tb_data; store palette bits.
  - c=RD_LAT+k, k=0..3: tg_rd=1, tg_addr = id_k*TILE_H + (line_y mod TILE_H).
  - c=2*RD_LAT+k: write tg_data into back buffer tile slot 4g+k.
  - After c=2*RD_LAT+3: g increments; g=GROUPS-1 goes to DONE.
  - Strobes are 0 in all other cycles. Address arithmetic truncates to TB_AW/TG_AW.
- DONE:
  - done=1 for one cycle, busy=0, return to IDLE.
  - Total latency: the done pulse comes GROUPS*(2*RD_LAT+4)+1 cycles after the line_start cycle.
  - Defaults (RD_LAT=1): 61 cycles.
- Swap:
  - line_swap with busy=0 toggles front select on the next edge.
  - line_swap while busy sets swap_pending; the toggle happens in the cycle done is asserted.
  - line_swap coinciding with line_start in IDLE: swap applies first; the fetch writes the new back buffer.
  - A second swap while pending is absorbed; only one toggle occurs.
- Pixel port:
  - sx = (px_x + scroll_x) mod LINE_PX, wrapping at line end.
  - tile = sx/16, p = sx mod 16.
  - One cycle later, px_index = front[tile] bits [2p+1:2p] and px_palette = front palette[tile].
  - Output is valid every cycle regardless of busy.
- Reset mid-fetch: abort at the next edge, strobes drop, no done pulse, swap_pending cleared.

Test Plan:
- Defaults, RD_LAT=1: tb word 0 = 0x83_02_81_00; line_start with line_y=5 -> tb_addr=0 at cycle 1; tg_addr sequence 5, 21, 37, 53; done exactly 61 cycles after line_start; busy high cycles 1..60.
- line_y=37 -> tb_addr sequence 20..29; tg_addr = id*16+5. After swap, tile 1 row 0x0000000C with palette 1 gives: px_x=17, scroll_x=0 -> px_index=3, px_palette=1 one cycle later.
- Wrap: scroll_x=630, px_x=20 -> sx=10 (LINE_PX=640); pixel 10 of tile 0 returned.
- line_swap pulsed at cycle 30 of a fetch -> front select unchanged until the done cycle, then toggles once; a second line_swap at cycle 40 -> still a single toggle.
- RD_LAT=3, TILES_PER_LINE=8 -> each group takes 10 cycles; done 21 cycles after line_start; tg_rd strobes at group offsets 3..6.
- Reset asserted at cycle 15 of a fetch -> next cycle busy=0, tb_rd=tg_rd=0, no done pulse; a new line_start is accepted immediately after reset deasserts.

Source files
------------

// File: rtl/ppu_line_fetcher.sv
// Background scanline fetch engine: loads tile IDs and tile rows into the back half of a
// double-buffered line store, and serves scrolled pixels from the front half.
module ppu_line_fetcher #(
  parameter int unsigned TILES_PER_LINE = 40,
  parameter int unsigned TILE_H         = 16,
  parameter int unsigned RD_LAT         = 1,
  parameter int unsigned TB_AW          = 9,
  parameter int unsigned TG_AW          = 11,
  parameter int unsigned Y_W            = 10,
  parameter int unsigned X_W            = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             line_start,
  input  logic [Y_W-1:0]   line_y,
  input  logic             line_swap,
  output logic             busy,
  output logic             done,
  output logic             tb_rd,
  output logic [TB_AW-1:0] tb_addr,
  input  logic [31:0]      tb_data,
  output logic             tg_rd,
  output logic [TG_AW-1:0] tg_addr,
  input  logic [31:0]      tg_data,
  input  logic [X_W-1:0]   px_x,
  input  logic [X_W-1:0]   scroll_x,
  output logic [1:0]       px_index,
  output logic             px_palette
);

  localparam int unsigned GROUPS  = TILES_PER_LINE / 4;
  localparam int unsigned LINE_PX = TILES_PER_LINE * 16;
  localparam int unsigned C_MAX   = 2 * RD_LAT + 3;
  localparam int unsigned C_W     = $clog2(C_MAX + 1);
  localparam int unsigned G_W     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int unsigned T_W     = (TILES_PER_LINE > 1) ? $clog2(TILES_PER_LINE) : 1;
  localparam int unsigned S_W     = X_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_GROUP, S_DONE} state_t;

  state_t             r_state, w_state_n;
  logic [C_W-1:0]     r_c, w_c_n;
  logic [G_W-1:0]     r_g, w_g_n;
  logic [Y_W-1:0]     r_y, w_y_n;
  logic               w_tb_rd_n, w_tg_rd_n;
  logic [TB_AW-1:0]   w_tb_addr_n;

  logic               r_busy, r_done, r_tb_rd, r_tg_rd;
  logic [TB_AW-1:0]   r_tb_addr;
  logic [6:0]         r_id [4];
  logic               r_front, r_pend;
  logic [1:0]         r_px_index;
  logic               r_px_pal;

  logic [31:0]        r_line [2][TILES_PER_LINE];
  logic               r_pal  [2][TILES_PER_LINE];

  // Next state plus the look-ahead values that feed the registered strobes
  always_comb begin
    w_state_n = r_state;
    w_c_n     = r_c;
    w_g_n     = r_g;
    w_y_n     = r_y;
    case (r_state)
      S_IDLE: begin
        if (line_start) begin
          w_state_n = S_GROUP;
          w_c_n     = '0;
          w_g_n     = '0;
          w_y_n     = line_y;
        end
      end
      S_GROUP: begin
        if (r_c == C_W'(C_MAX)) begin
          w_c_n = '0;
          if (r_g == G_W'(GROUPS - 1)) w_state_n = S_DONE;
          else                         w_g_n     = r_g + G_W'(1);
        end else begin
          w_c_n = r_c + C_W'(1);
        end
      end
      S_DONE:  w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
    w_tb_rd_n   = (w_state_n == S_GROUP) && (w_c_n == '0);
    w_tb_addr_n = TB_AW'((32'(w_y_n) / TILE_H) * GROUPS + 32'(w_g_n));
    w_tg_rd_n   = (w_state_n == S_GROUP) && (w_c_n >= C_W'(RD_LAT)) &&
                  (w_c_n <= C_W'(RD_LAT + 3));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_c     <= '0;
      r_g     <= '0;
      r_y     <= '0;
    end else begin
      r_state <= w_state_n;
      r_c     <= w_c_n;
      r_g     <= w_g_n;
      r_y     <= w_y_n;
    end
  end

  // Current-cycle decode of the group schedule
  logic             w_cap, w_wr, w_end, w_toggle, w_back;
  logic [1:0]       w_tg_k, w_wr_k;
  logic [6:0]       w_id;
  logic [T_W-1:0]   w_slot;

  assign w_cap    = (r_state == S_GROUP) && (r_c == C_W'(RD_LAT));
  assign w_wr     = (r_state == S_GROUP) && (r_c >= C_W'(2 * RD_LAT));
  assign w_tg_k   = 2'(r_c - C_W'(RD_LAT));
  assign w_wr_k   = 2'(r_c - C_W'(2 * RD_LAT));
  assign w_slot   = T_W'(32'(r_g) * 4 + 32'(w_wr_k));
  assign w_back   = ~r_front;
  // Entry 0 is used in the very cycle tile-buffer data arrives, so bypass the capture register
  assign w_id     = w_cap ? tb_data[6:0] : r_id[w_tg_k];
  assign w_end    = (r_state == S_GROUP) && (w_state_n == S_DONE);
  assign w_toggle = (line_swap && (r_state != S_GROUP)) || (w_end && (r_pend || line_swap));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_tb_rd   <= 1'b0;
      r_tg_rd   <= 1'b0;
      r_tb_addr <= '0;
      r_front   <= 1'b0;
      r_pend    <= 1'b0;
      for (int k = 0; k < 4; k++) r_id[k] <= '0;
    end else begin
      r_busy  <= (w_state_n == S_GROUP);
      r_done  <= (w_state_n == S_DONE);
      r_tb_rd <= w_tb_rd_n;
      r_tg_rd <= w_tg_rd_n;
      if (w_tb_rd_n) r_tb_addr <= w_tb_addr_n;
      if (w_toggle)  r_front   <= ~r_front;
      if (w_end)                                  r_pend <= 1'b0;
      else if ((r_state == S_GROUP) && line_swap) r_pend <= 1'b1;
      if (w_cap) for (int k = 0; k < 4; k++) r_id[k] <= tb_data[8*k +: 7];
    end
  end

  // Line store writes into the back half
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (w_cap)
        for (int k = 0; k < 4; k++)
          r_pal[w_back][T_W'(32'(r_g) * 4 + 32'(k))] <= tb_data[8*k + 7];
      if (w_wr) r_line[w_back][w_slot] <= tg_data;
    end
  end

  // Pixel port: scrolled, wrapped lookup into the front half
  logic [S_W-1:0] w_sum, w_sx;
  logic [T_W-1:0] w_tile;
  logic [3:0]     w_p;

  assign w_sum  = S_W'(px_x) + S_W'(scroll_x);
  assign w_sx   = S_W'(32'(w_sum) % LINE_PX);
  assign w_tile = T_W'(w_sx >> 4);
  assign w_p    = w_sx[3:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_px_index <= 2'b00;
      r_px_pal   <= 1'b0;
    end else begin
      r_px_index <= 2'(r_line[r_front][w_tile] >> {w_p, 1'b0});
      r_px_pal   <= r_pal[r_front][w_tile];
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign tb_rd      = r_tb_rd;
  assign tb_addr    = r_tb_addr;
  assign tg_rd      = r_tg_rd;
  assign tg_addr    = r_tg_rd ? TG_AW'(32'(w_id) * TILE_H + 32'(r_y) % TILE_H) : '0;
  assign px_index   = r_px_index;
  assign px_palette = r_px_pal;

endmodule
